// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bundle: instruction memory port, decode handshake, control strobes.
// The fetch controller is the master; the core/memory side is the slave.
interface ifetch_ctrl_if;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    modport master (
        input  start, imem_data, redirect, redirect_pc, instr_ready,
        output imem_addr, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, imem_data, redirect, redirect_pc, instr_ready,
        input  imem_addr, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational IMEM into a
// small circular queue toward decode, handles branch redirects and halt on zero word.
module ifetch_ctrl #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter int         FQ_DEPTH     = 2,
    parameter bit         HALT_ON_ZERO = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ifetch_ctrl_if.master bus
);
    localparam int PTR_W = (FQ_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = (FQ_DEPTH > 3) ? 3 : 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FQ_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FQ_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       r_state;
    logic [7:0]       r_pc;
    logic [15:0]      r_q_instr [FQ_DEPTH];
    logic [7:0]       r_q_pc    [FQ_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_valid;
    logic w_pop;
    logic w_zero;
    logic w_can_fetch;
    logic w_push;
    logic w_halt_go;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & bus.instr_ready;
    assign w_zero      = HALT_ON_ZERO && (bus.imem_data == 16'h0000);
    // A fetch slot exists when the queue has room or the head leaves this same edge.
    assign w_can_fetch = (r_state == S_RUN) && !bus.redirect && ((r_count != CNT_FULL) || w_pop);
    assign w_push      = w_can_fetch && !w_zero;
    assign w_halt_go   = w_can_fetch && w_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC & 8'hFE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.redirect) begin
            // Redirect flushes everything, including an entry popped this same edge.
            r_pc    <= bus.redirect_pc & 8'hFE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            if (r_state != S_IDLE) r_state <= S_RUN;
        end else begin
            if (r_state == S_IDLE && bus.start) r_state <= S_RUN;
            if (w_halt_go) r_state <= S_HALT;
            if (w_push) begin
                r_pc   <= r_pc + 8'd2;
                r_tail <= f_next(r_tail);
            end
            if (w_pop) r_head <= f_next(r_head);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= bus.imem_data;
            r_q_pc[r_tail]    <= r_pc;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? r_q_instr[r_head] : 16'h0000;
    assign bus.instr_pc    = w_valid ? r_q_pc[r_head] : 8'h00;
    assign bus.halted      = (r_state == S_HALT);
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic,
// compared against a queue-level behavioural model of the fetch rules.
module tb_ifetch_ctrl;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_ctrl_if bus ();
    ifetch_ctrl #(.RESET_PC(8'h00), .FQ_DEPTH(D), .HALT_ON_ZERO(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.master)
    );

    logic [15:0] mem [128];
    assign bus.imem_data = mem[bus.imem_addr[7:1]];

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: PC, run/halt flags and a plain queue of fetched words.
    logic [7:0]  m_pc;
    bit          m_run, m_halt;
    logic [15:0] mq_d [$];
    logic [7:0]  mq_pc [$];
    logic [7:0]  got [$];

    task automatic model_reset();
        m_pc = 8'h00; m_run = 0; m_halt = 0;
        mq_d.delete(); mq_pc.delete();
    endtask

    task automatic model_edge();
        int sz;
        bit pop;
        logic [15:0] w;
        sz  = mq_d.size();
        pop = (sz > 0) && bus.instr_ready;
        w   = mem[m_pc[7:1]];
        if (pop) begin void'(mq_d.pop_front()); void'(mq_pc.pop_front()); end
        if (bus.redirect) begin
            if (m_run || m_halt) begin
                mq_d.delete(); mq_pc.delete(); m_run = 1; m_halt = 0;
            end
            m_pc = bus.redirect_pc & 8'hFE;
        end else if (!m_run && !m_halt) begin
            if (bus.start) m_run = 1;
        end else if (m_run && (sz < D || pop)) begin
            if (w == 16'h0000) begin
                m_run = 0; m_halt = 1;
            end else begin
                mq_d.push_back(w); mq_pc.push_back(m_pc); m_pc = m_pc + 8'd2;
            end
        end
    endtask

    function automatic logic [33:0] model_vec();
        logic v;
        v = (mq_pc.size() > 0);
        return {v, v ? mq_d[0] : 16'h0, v ? mq_pc[0] : 8'h0, m_pc, m_halt};
    endfunction

    function automatic logic [33:0] dut_vec();
        return {bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr, bus.halted};
    endfunction

    task automatic tick();
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) got.push_back(bus.instr_pc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        bus.start = 0; bus.redirect = 0; bus.redirect_pc = 8'h00; bus.instr_ready = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
    endtask

    task automatic fill_mem(input int nz_words);
        for (int i = 0; i < 128; i++)
            mem[i] = (i < nz_words) ? 16'($urandom_range(1, 65535)) : 16'h0000;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (dut_vec() !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 34'h0);
        end
    endtask

    task automatic test_program();
        bit zero_seen = 0;
        do_reset();
        fill_mem(19);
        bus.instr_ready = 1; bus.start = 1; tick(); bus.start = 0;
        n_chk++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL start_latency_n1: valid=%b addr=%h expected 0/00", bus.instr_valid, bus.imem_addr);
        end
        tick();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr !== mem[0]) begin
            n_fail++;
            $display("FAIL start_latency_n2: valid=%b pc=%h instr=%h expected 1/00/%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, mem[0]);
        end
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.instr_valid === 1'b1 && bus.instr === 16'h0000) zero_seen = 1;
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL program_cycle%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        n_chk++;
        if (got.size() != 19) begin
            n_fail++;
            $display("FAIL program_count: got %0d instrs expected 19", got.size());
        end else begin
            for (int i = 0; i < 19; i++) begin
                n_chk++;
                if (got[i] !== 8'(2 * i)) begin
                    n_fail++;
                    $display("FAIL program_order[%0d]: got %h expected %h", i, got[i], 8'(2 * i));
                end
            end
        end
        n_chk++;
        if (bus.halted !== 1'b1 || bus.imem_addr !== 8'h26 || zero_seen) begin
            n_fail++;
            $display("FAIL program_halt: halted=%b addr=%h zero_seen=%b expected 1/26/0",
                     bus.halted, bus.imem_addr, zero_seen);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_mem(64);
        bus.instr_ready = 0; bus.start = 1; tick(); bus.start = 0;
        repeat (4) tick();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.imem_addr !== 8'h04) begin
            n_fail++;
            $display("FAIL full_hold: valid=%b pc=%h addr=%h expected 1/00/04",
                     bus.instr_valid, bus.instr_pc, bus.imem_addr);
        end
        bus.instr_ready = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL drain_cycle%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (i >= got.size() || got[i] !== 8'(2 * i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, 8'(2 * i));
            end
        end
    endtask

    task automatic test_redirect_full();
        bus.instr_ready = 0;
        repeat (3) tick();
        bus.redirect = 1; bus.redirect_pc = 8'h11; tick(); bus.redirect = 0;
        n_chk++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h10) begin
            n_fail++;
            $display("FAIL redirect_flush: valid=%b addr=%h expected 0/10", bus.instr_valid, bus.imem_addr);
        end
        tick();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h10) begin
            n_fail++;
            $display("FAIL redirect_first: valid=%b pc=%h expected 1/10", bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_wrap();
        mem[126] = 16'h1111; mem[127] = 16'h2222; mem[0] = 16'h3333; mem[1] = 16'h4444;
        bus.instr_ready = 1; bus.redirect = 1; bus.redirect_pc = 8'hFC; tick(); bus.redirect = 0;
        got.delete();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL wrap_cycle%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        n_chk++;
        if (got.size() < 4 || got[0] !== 8'hFC || got[1] !== 8'hFE || got[2] !== 8'h00 || got[3] !== 8'h02) begin
            n_fail++;
            $display("FAIL wrap_seq: got %p expected FC FE 00 02", got);
        end
    endtask

    task automatic test_halt_resume();
        mem[64] = 16'h0000;
        bus.instr_ready = 1; bus.redirect = 1; bus.redirect_pc = 8'h80; tick(); bus.redirect = 0;
        tick();
        n_chk++;
        if (bus.halted !== 1'b1 || bus.imem_addr !== 8'h80 || bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b addr=%h valid=%b expected 1/80/0",
                     bus.halted, bus.imem_addr, bus.instr_valid);
        end
        bus.redirect = 1; bus.redirect_pc = 8'h00; tick(); bus.redirect = 0;
        n_chk++;
        if (bus.halted !== 1'b0 || bus.imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL halt_exit: halted=%b addr=%h expected 0/00", bus.halted, bus.imem_addr);
        end
        tick();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr !== mem[0]) begin
            n_fail++;
            $display("FAIL halt_resume: valid=%b pc=%h expected 1/00", bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_mem(64);
        bus.instr_ready = 1; bus.start = 1; tick(); bus.start = 0;
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h00 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b addr=%h halted=%b expected 0/00/0",
                     bus.instr_valid, bus.imem_addr, bus.halted);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h00 || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL idle_after_reset%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 128; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
        for (int c = 0; c < 800; c++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = 8'($urandom_range(0, 255));
            tick();
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        bus.start = 0; bus.redirect = 0;
    endtask

    initial begin
        bus.start = 0; bus.redirect = 0; bus.redirect_pc = 8'h00; bus.instr_ready = 0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        model_reset();
        test_reset();
        test_program();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_halt_resume();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
